// File: rtl/guess_entry.sv
// guess_entry: debounced keypad editor for a 4-digit guess with valid/ready handoff; GUESS_UNIQUE_EN rejects repeated digits
module guess_entry #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        guess_ready,
  output logic        guess_valid,
  output logic [15:0] guess,
  output logic [3:0]  d0,
  output logic [3:0]  d1,
  output logic [3:0]  d2,
  output logic [3:0]  d3,
  output logic [2:0]  count,
  output logic        reject
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, SUBMIT} state_t;
  state_t state;
  logic [3:0] code_q;
  logic [CW-1:0] cnt;
  logic [3:0] d [4];
  logic [3:0] n_d [4];
  logic [2:0] n_count;
  logic n_rej, n_sub, dup, fire;
  logic [1:0] wr_idx, bs_idx;
  assign {d0, d1, d2, d3} = {d[0], d[1], d[2], d[3]};
  assign wr_idx = count[1:0];
  assign bs_idx = 2'(count - 3'd1);
`ifdef GUESS_UNIQUE_EN
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < 4; i++) dup = dup | (3'(i) < count && d[i] == key_code);
  end
`else
  assign dup = 1'b0;
`endif
  always_comb begin
    n_d = d;
    n_count = count;
    n_rej = 1'b0;
    n_sub = 1'b0;
    if (key_code < 4'd10) begin
      if (count == 3'd4 || dup) n_rej = 1'b1;
      else begin
        n_d[wr_idx] = key_code;
        n_count = count + 3'd1;
      end
    end else if (key_code == 4'hA) begin
      if (count == 3'd0) n_rej = 1'b1;
      else begin
        n_d[bs_idx] = 4'hF;
        n_count = count - 3'd1;
      end
    end else if (key_code == 4'hB) begin
      n_d = '{default: 4'hF};
      n_count = 3'd0;
    end else if (key_code == 4'hC) begin
      n_sub = count == 3'd4;
      n_rej = count != 3'd4;
    end
  end
  // the acting code is always the live key_code: in DEBOUNCE it must equal the latch to fire
  assign fire = key_valid && ((state == IDLE && DEBOUNCE_CYCLES == 1) ||
                (state == DEBOUNCE && key_code == code_q && cnt + CW'(1) == CW'(DEBOUNCE_CYCLES)));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      code_q <= 4'h0;
      cnt <= '0;
      d <= '{default: 4'hF};
      count <= 3'd0;
      guess <= 16'h0;
      guess_valid <= 1'b0;
      reject <= 1'b0;
    end else begin
      reject <= 1'b0;
      case (state)
        IDLE: if (key_valid) begin
          state <= DEBOUNCE;
          code_q <= key_code;
          cnt <= CW'(1);
        end
        DEBOUNCE: if (!key_valid) state <= IDLE;
          else if (key_code != code_q) begin
            code_q <= key_code;
            cnt <= CW'(1);
          end else cnt <= cnt + CW'(1);
        HELD: if (!key_valid) state <= IDLE;
        SUBMIT: if (guess_ready) begin
          d <= '{default: 4'hF};
          count <= 3'd0;
          guess_valid <= 1'b0;
          state <= HELD;
        end
        default: state <= IDLE;
      endcase
      if (fire) begin
        d <= n_d;
        count <= n_count;
        reject <= n_rej;
        state <= n_sub ? SUBMIT : HELD;
        if (n_sub) begin
          guess <= {d[0], d[1], d[2], d[3]};
          guess_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_guess_entry.sv
// tb_guess_entry: directed keypad presses checked every cycle against a press-level model plus literal checkpoints
module tb_guess_entry;
  localparam int DC = 4;
  logic clk = 1'b0, rst = 1'b0, key_valid = 1'b0, guess_ready = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic guess_valid, reject;
  logic [15:0] guess;
  logic [3:0] d0, d1, d2, d3;
  logic [2:0] count;
  logic [3:0] dd [4];
  int total = 0, bad = 0, gv_cycles = 0, rej_cycles = 0;
  logic [3:0] mq[$];
  int run = 0;
  logic [3:0] last = 4'h0;
  bit acted = 0, m_gv = 0, m_rej = 0;
  logic [15:0] m_guess = 16'h0;

  guess_entry #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .guess_ready(guess_ready), .guess_valid(guess_valid), .guess(guess),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .count(count), .reject(reject)
  );

  always #5 clk = ~clk;
  assign dd = '{d0, d1, d2, d3};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_d(input int i);
    return i < mq.size() ? mq[i] : 4'hF;
  endfunction

  task automatic m_apply(input logic [3:0] c);
    bit dup;
    dup = 0;
`ifdef GUESS_UNIQUE_EN
    foreach (mq[i]) if (mq[i] == c) dup = 1;
`endif
    if (c < 10) begin
      if (mq.size() == 4 || dup) m_rej = 1;
      else mq.push_back(c);
    end else if (c == 4'hA) begin
      if (mq.size() == 0) m_rej = 1;
      else void'(mq.pop_back());
    end else if (c == 4'hB) mq.delete();
    else if (c == 4'hC) begin
      if (mq.size() == 4) begin
        m_guess = {mq[0], mq[1], mq[2], mq[3]};
        m_gv = 1;
      end else m_rej = 1;
    end
  endtask

  // model: one action per press once the same code has been seen DC edges in a row
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      mq.delete();
      run = 0; acted = 0; m_gv = 0; m_rej = 0; m_guess = 16'h0;
    end else begin
      m_rej = 0;
      if (m_gv) begin
        if (guess_ready) begin
          mq.delete();
          m_gv = 0;
        end
        run = 0;
        acted = 1;
      end else if (!key_valid) begin
        run = 0;
        acted = 0;
      end else if (!acted) begin
        run = (run > 0 && key_code == last) ? run + 1 : 1;
        last = key_code;
        if (run == DC) begin
          acted = 1;
          m_apply(key_code);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      check("guess_valid", 32'(guess_valid), 32'(m_gv));
      check("guess", 32'(guess), 32'(m_guess));
      check("count", 32'(count), 32'(mq.size()));
      check("reject", 32'(reject), 32'(m_rej));
      for (int i = 0; i < 4; i++) check($sformatf("d%0d", i), 32'(dd[i]), 32'(m_d(i)));
      if (guess_valid) gv_cycles++;
      if (reject) rej_cycles++;
    end
  end

  task automatic press(input logic [3:0] c, input int hold = 6);
    key_valid = 1; key_code = c;
    repeat (hold) @(posedge clk);
    #1 key_valid = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_gv", 32'(guess_valid), 0);
    check("rst_count", 32'(count), 0);
    check("rst_digits", 32'({d0, d1, d2, d3}), 32'h0000FFFF);
    check("rst_guess", 32'(guess), 0);
    check("rst_reject", 32'(reject), 0);
    rst = 1;
    @(posedge clk); #1;
    press(1); press(2); press(3); press(4);
    gv_cycles = 0;
    guess_ready = 1;
    press(4'hC);
    guess_ready = 0;
    check("t1_guess", 32'(guess), 32'h1234);
    check("t1_gv_width", 32'(gv_cycles), 1);
    check("t1_cleared", 32'({count, d0, d1, d2, d3}), 32'h0FFFF);
    press(5); press(6); press(4'hA); press(7);
    check("t2_buf", 32'({count, d0, d1, d2}), 32'h257F);
    gv_cycles = 0; rej_cycles = 0;
    press(4'hC);
    check("t2_reject", 32'(rej_cycles), 1);
    check("t2_no_gv", 32'(gv_cycles), 0);
    press(8, 3);
    check("t3_glitch", 32'({count, d0, d1}), 32'h257);
    press(4'hB);
    key_valid = 1; key_code = 8;
    repeat (2) @(posedge clk);
    #1 key_code = 9;
    repeat (4) @(posedge clk);
    #1 key_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    check("t3_restart", 32'({count, d0, d1}), 32'h19F);
    press(1); press(2); press(3);
    rej_cycles = 0;
    press(0);
    check("t4_full_rej", 32'(rej_cycles), 1);
    check("t4_full_buf", 32'({count, d0, d1, d2, d3}), 32'h49123);
    gv_cycles = 0;
    press(4'hC);
    press(5);
    check("t4_gv_held", 32'(gv_cycles >= 5), 1);
    check("t4_guess", 32'({guess_valid, guess}), 32'h19123);
    check("t4_ignored", 32'(count), 4);
    guess_ready = 1;
    @(posedge clk); #1;
    guess_ready = 0;
    check("t4_handshake", 32'({guess_valid, count, d0}), 32'h0F);
    repeat (2) @(posedge clk);
    #1;
    check("t4_guess_kept", 32'(guess), 32'h9123);
    press(4'hB);
    rej_cycles = 0;
    press(3); press(3);
`ifdef GUESS_UNIQUE_EN
    check("t5_unique", 32'({count, d0, d1}), 32'h13F);
    check("t5_rej", 32'(rej_cycles), 1);
`else
    check("t5_dup", 32'({count, d0, d1}), 32'h233);
    check("t5_rej", 32'(rej_cycles), 0);
`endif
    press(4'hB);
    press(1); press(2); press(3); press(4);
    press(4'hC);
    check("t6_in_submit", 32'(guess_valid), 1);
    @(posedge clk);
    #3 rst = 0;
    #1;
    check("t6_async_rst", 32'({guess_valid, count, d0, d1, d2, d3}), 32'h0FFFF);
    @(posedge clk); #1;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    check("t6_after", 32'({guess_valid, count}), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
